uart_rx_frame_ctrl: RTL and testbench

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

---
 rtl/uart_rx_frame_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Frame assembler sitting behind a byte-level UART receiver. It hunts for a
// sync byte, collects CMD, LEN, payload and checksum, then holds the verified
// frame for a consumer until it is acknowledged. Line errors, bad lengths,
// bad checksums, inter-byte timeouts and bytes dropped while a frame is held
// are each reported as single-cycle pulses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// HUNT  0  | idle, discarding bytes until SYNC_BYTE arrives
// CMD   1  | waiting for the command byte
// LEN   2  | waiting for the payload length byte
// PAYLOAD 3| storing payload bytes into the buffer
// CSUM  4  | waiting for the checksum byte
// HOLD  5  | verified frame presented on frame_* / rd_data until frame_ack
// 6, 7     | unused, fall back to HUNT

module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         MAX_PAYLOAD   = 16,
  parameter int         TIMEOUT_TICKS = 4096
) (
  input  logic       baud,
  input  logic       rst,
  input  logic       ctrl_en,
  output logic       rx_enable,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rx_busy,
  input  logic       rx_error,
  output logic       frame_valid,
  input  logic       frame_ack,
  output logic [7:0] frame_cmd,
  output logic [4:0] frame_len,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       err_line,
  output logic       err_len,
  output logic       err_csum,
  output logic       err_timeout,
  output logic       err_drop,
  output logic [2:0] state
);

  localparam int              IDX_W   = $clog2(MAX_PAYLOAD);
  localparam int              TO_W    = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [7:0]      MAX_LEN = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CSUM    = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  state_t          cur_state;
  logic [7:0]      acc;
  logic [4:0]      idx;
  logic [7:0]      cmd_q;
  logic [4:0]      len_q;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      buffer [MAX_PAYLOAD];
  logic            in_frame;
  logic            is_sync;

  // Frame-in-progress states share the abort and timeout rules.
  assign in_frame = (cur_state == S_CMD) || (cur_state == S_LEN) ||
                    (cur_state == S_PAYLOAD) || (cur_state == S_CSUM);
  assign is_sync  = (rx_data == SYNC_BYTE);
  assign state    = cur_state;

  // Frame sequencer: state, working registers, published frame and error pulses.
  always_ff @(posedge baud) begin
    if (rst) begin
      cur_state   <= S_HUNT;
      rx_enable   <= 1'b0;
      frame_valid <= 1'b0;
      frame_cmd   <= 8'h00;
      frame_len   <= 5'd0;
      cmd_q       <= 8'h00;
      len_q       <= 5'd0;
      acc         <= 8'h00;
      idx         <= 5'd0;
      to_cnt      <= '0;
      err_line    <= 1'b0;
      err_len     <= 1'b0;
      err_csum    <= 1'b0;
      err_timeout <= 1'b0;
      err_drop    <= 1'b0;
    end else begin
      rx_enable   <= ctrl_en;
      err_line    <= 1'b0;
      err_len     <= 1'b0;
      err_csum    <= 1'b0;
      err_timeout <= 1'b0;
      err_drop    <= 1'b0;
      // Counter only survives idle cycles inside a frame; everything else clears it.
      to_cnt      <= '0;

      if (!ctrl_en) begin
        // Disable wins over every other event; buffer contents are left alone.
        cur_state   <= S_HUNT;
        frame_valid <= 1'b0;
      end else if (in_frame && rx_error) begin
        err_line  <= 1'b1;
        cur_state <= S_HUNT;
      end else if (in_frame && !rx_done) begin
        if (!rx_busy) begin
          if (to_cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            cur_state   <= S_HUNT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
      end else begin
        case (cur_state)
          S_HUNT: begin
            if (rx_error) begin
              err_line <= 1'b1;
            end else if (rx_done && is_sync) begin
              cur_state <= S_CMD;
              acc       <= 8'h00;
              idx       <= 5'd0;
            end
          end

          S_CMD: begin
            cmd_q     <= rx_data;
            acc       <= acc + rx_data;
            cur_state <= S_LEN;
          end

          S_LEN: begin
            if (rx_data > MAX_LEN) begin
              err_len   <= 1'b1;
              cur_state <= S_HUNT;
            end else begin
              len_q     <= rx_data[4:0];
              acc       <= acc + rx_data;
              cur_state <= (rx_data == 8'h00) ? S_CSUM : S_PAYLOAD;
            end
          end

          S_PAYLOAD: begin
            buffer[idx[IDX_W-1:0]] <= rx_data;
            acc <= acc + rx_data;
            idx <= idx + 5'd1;
            if ((idx + 5'd1) == len_q) begin
              cur_state <= S_CSUM;
            end
          end

          S_CSUM: begin
            if (rx_data == acc) begin
              // Publish the frame only once it has been verified.
              cur_state   <= S_HOLD;
              frame_valid <= 1'b1;
              frame_cmd   <= cmd_q;
              frame_len   <= len_q;
            end else begin
              err_csum  <= 1'b1;
              cur_state <= S_HUNT;
            end
          end

          S_HOLD: begin
            err_line <= rx_error;
            if (frame_ack) begin
              // Release the frame; a byte arriving on the same cycle is hunted.
              frame_valid <= 1'b0;
              if (rx_done && !rx_error && is_sync) begin
                cur_state <= S_CMD;
                acc       <= 8'h00;
                idx       <= 5'd0;
              end else begin
                cur_state <= S_HUNT;
              end
            end else if (rx_done && !rx_error) begin
              err_drop <= 1'b1;
            end
          end

          default: begin
            cur_state   <= S_HUNT;
            frame_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  // Payload read port; indices past the held length read as zero.
  always_comb begin
    rd_data = 8'h00;
    if ({1'b0, rd_addr} < frame_len) begin
      rd_data = buffer[rd_addr];
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl: table of whole frames checked through a
// scoreboard queue, plus hand-written sequences for hold/drop, timeout,
// line error, disable and reset-mid-frame cases.

module tb_uart_rx_frame_ctrl;

  localparam int T_TICKS = 4096;
  localparam int NV      = 7;

  logic       baud = 1'b0;
  logic       rst, ctrl_en, rx_done, rx_busy, rx_error, frame_ack;
  logic [7:0] rx_data;
  logic [3:0] rd_addr;
  logic       rx_enable, frame_valid;
  logic [7:0] frame_cmd, rd_data;
  logic [4:0] frame_len;
  logic       err_line, err_len, err_csum, err_timeout, err_drop;
  logic [2:0] state;

  uart_rx_frame_ctrl dut (
    .baud(baud), .rst(rst), .ctrl_en(ctrl_en), .rx_enable(rx_enable),
    .rx_data(rx_data), .rx_done(rx_done), .rx_busy(rx_busy), .rx_error(rx_error),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_cmd(frame_cmd),
    .frame_len(frame_len), .rd_addr(rd_addr), .rd_data(rd_data),
    .err_line(err_line), .err_len(err_len), .err_csum(err_csum),
    .err_timeout(err_timeout), .err_drop(err_drop), .state(state)
  );

  always #5 baud = ~baud;

  typedef struct packed {
    logic [159:0]    b;        // bytes right-aligned, last byte in the LSBs
    int              n;
    logic            valid;
    logic [7:0]      cmd;
    logic [4:0]      len;
    logic [2:0][3:0] ra;
    logic [2:0][7:0] rd;
    logic [2:0]      st;
    int              csum_err;
    int              len_err;
  } vec_t;

  vec_t vecs [NV];
  vec_t sb_q [$];

  int n_cmp = 0;
  int n_fail = 0;
  int c_line = 0, c_len = 0, c_csum = 0, c_to = 0, c_drop = 0, c_long = 0;
  logic [4:0] prev_err = 5'd0;

  // Error pulse monitor: counts pulses and flags any pulse wider than one cycle.
  always @(negedge baud) begin
    if (err_line)    c_line++;
    if (err_len)     c_len++;
    if (err_csum)    c_csum++;
    if (err_timeout) c_to++;
    if (err_drop)    c_drop++;
    if (({err_line, err_len, err_csum, err_timeout, err_drop} & prev_err) != 5'd0) c_long++;
    prev_err = {err_line, err_len, err_csum, err_timeout, err_drop};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge baud);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    rx_busy = 1'b1;
    tick();
    tick();
    rx_busy = 1'b0;
    rx_data = v;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  function automatic vec_t mkv(input logic [159:0] b, input int n, input logic valid,
                               input logic [7:0] cmd, input logic [4:0] len,
                               input logic [11:0] ra, input logic [23:0] rd,
                               input logic [2:0] st, input int csum_err, input int len_err);
    vec_t v;
    v.b = b; v.n = n; v.valid = valid; v.cmd = cmd; v.len = len;
    v.ra = ra; v.rd = rd; v.st = st; v.csum_err = csum_err; v.len_err = len_err;
    return v;
  endfunction

  initial begin
    int b_line, b_len, b_csum, b_to, b_drop, n;
    logic fired;
    vec_t e;

    vecs[0] = mkv(160'({8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h15}), 6, 1'b1, 8'h10, 5'd2,
                  {4'd0, 4'd1, 4'd2}, {8'h01, 8'h02, 8'h00}, 3'd5, 0, 0);
    vecs[1] = mkv(160'({8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h16}), 6, 1'b0, 8'h00, 5'd0,
                  12'h0, 24'h0, 3'd0, 1, 0);
    vecs[2] = mkv(160'({8'hA5, 8'h20, 8'h11}), 3, 1'b0, 8'h00, 5'd0,
                  12'h0, 24'h0, 3'd0, 0, 1);
    vecs[3] = mkv(160'({8'hA5, 8'h20, 8'h00, 8'h20}), 4, 1'b1, 8'h20, 5'd0,
                  {4'd0, 4'd1, 4'd15}, {8'h00, 8'h00, 8'h00}, 3'd5, 0, 0);
    vecs[4] = mkv(160'({8'h00, 8'hFF, 8'hA5, 8'h33, 8'h01, 8'h7E, 8'hB2}), 7, 1'b1, 8'h33, 5'd1,
                  {4'd0, 4'd1, 4'd2}, {8'h7E, 8'h00, 8'h00}, 3'd5, 0, 0);
    vecs[5] = mkv(160'({8'hA5, 8'hC3, 8'h10,
                        8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                        8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10,
                        8'h5B}), 20, 1'b1, 8'hC3, 5'd16,
                  {4'd0, 4'd14, 4'd15}, {8'h01, 8'h0F, 8'h10}, 3'd5, 0, 0);
    vecs[6] = mkv(160'({8'hA5, 8'hFF, 8'h02, 8'h80, 8'h90, 8'h11}), 6, 1'b1, 8'hFF, 5'd2,
                  {4'd0, 4'd1, 4'd2}, {8'h80, 8'h90, 8'h00}, 3'd5, 0, 0);

    rst = 1'b1; ctrl_en = 1'b1; rx_done = 1'b0; rx_busy = 1'b0; rx_error = 1'b0;
    frame_ack = 1'b0; rx_data = 8'h00; rd_addr = 4'd0;
    repeat (3) tick();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_rx_enable", 32'(rx_enable), 32'd0);
    chk("reset_valid", 32'(frame_valid), 32'd0);
    chk("reset_len", 32'(frame_len), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    tick();
    chk("rx_enable_after_reset", 32'(rx_enable), 32'd1);

    // Table of frames through the scoreboard queue.
    for (int k = 0; k < NV; k++) begin
      b_line = c_line; b_len = c_len; b_csum = c_csum; b_to = c_to; b_drop = c_drop;
      sb_q.push_back(vecs[k]);
      for (int i = 0; i < vecs[k].n; i++) begin
        send_byte(vecs[k].b[8*(vecs[k].n-1-i) +: 8]);
      end
      chk($sformatf("v%0d_valid_next_cycle", k), 32'(frame_valid), 32'(vecs[k].valid));
      @(negedge baud);
      #1;
      e = sb_q.pop_front();
      chk($sformatf("v%0d_state", k), 32'(state), 32'(e.st));
      chk($sformatf("v%0d_err_csum", k), 32'(c_csum - b_csum), 32'(e.csum_err));
      chk($sformatf("v%0d_err_len", k), 32'(c_len - b_len), 32'(e.len_err));
      chk($sformatf("v%0d_err_other", k), 32'((c_line - b_line) + (c_to - b_to) + (c_drop - b_drop)), 32'd0);
      if (e.valid) begin
        chk($sformatf("v%0d_cmd", k), 32'(frame_cmd), 32'(e.cmd));
        chk($sformatf("v%0d_len", k), 32'(frame_len), 32'(e.len));
        for (int j = 0; j < 3; j++) begin
          rd_addr = e.ra[j];
          #1;
          chk($sformatf("v%0d_rd%0d", k, e.ra[j]), 32'(rd_data), 32'(e.rd[j]));
        end
      end
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      chk($sformatf("v%0d_released", k), 32'(frame_valid), 32'd0);
    end

    // Hold, drop, error-in-hold, then ack together with a new sync byte.
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h15);
    chk("hold_valid", 32'(frame_valid), 32'd1);
    b_drop = c_drop;
    send_byte(8'h55);
    @(negedge baud); #1;
    chk("drop_pulse", 32'(c_drop - b_drop), 32'd1);
    chk("drop_state", 32'(state), 32'd5);
    chk("drop_valid", 32'(frame_valid), 32'd1);
    chk("drop_cmd", 32'(frame_cmd), 32'h10);
    chk("drop_len", 32'(frame_len), 32'd2);
    rd_addr = 4'd1; #1;
    chk("drop_rd1", 32'(rd_data), 32'h02);
    b_line = c_line;
    rx_error = 1'b1; tick(); rx_error = 1'b0;
    @(negedge baud); #1;
    chk("hold_line_pulse", 32'(c_line - b_line), 32'd1);
    chk("hold_line_state", 32'(state), 32'd5);
    frame_ack = 1'b1; rx_done = 1'b1; rx_data = 8'hA5;
    tick();
    frame_ack = 1'b0; rx_done = 1'b0;
    chk("ack_sync_state", 32'(state), 32'd1);
    chk("ack_sync_valid", 32'(frame_valid), 32'd0);

    // ctrl_en low mid-frame.
    ctrl_en = 1'b0; tick();
    chk("dis_state", 32'(state), 32'd0);
    chk("dis_rx_enable", 32'(rx_enable), 32'd0);
    ctrl_en = 1'b1; tick();
    chk("en_rx_enable", 32'(rx_enable), 32'd1);

    // ctrl_en low with a frame held.
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h00); send_byte(8'h20);
    chk("dis_hold_pre", 32'(frame_valid), 32'd1);
    ctrl_en = 1'b0; tick();
    chk("dis_hold_valid", 32'(frame_valid), 32'd0);
    chk("dis_hold_state", 32'(state), 32'd0);
    ctrl_en = 1'b1; tick();

    // Inter-byte timeout after A5 10.
    b_to = c_to;
    send_byte(8'hA5); send_byte(8'h10);
    n = 0; fired = 1'b0;
    while (n < T_TICKS + 200 && !fired) begin
      tick();
      n++;
      if (err_timeout) fired = 1'b1;
    end
    chk("timeout_fired", 32'(fired), 32'd1);
    chk("timeout_cycles", 32'(n), 32'(T_TICKS));
    repeat (5) tick();
    chk("timeout_single", 32'(c_to - b_to), 32'd1);
    chk("timeout_state", 32'(state), 32'd0);

    // Line error mid-payload.
    b_line = c_line;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03); send_byte(8'h01);
    chk("pre_error_state", 32'(state), 32'd3);
    rx_error = 1'b1; tick(); rx_error = 1'b0;
    chk("line_state", 32'(state), 32'd0);
    @(negedge baud); #1;
    chk("line_pulse", 32'(c_line - b_line), 32'd1);

    // Reset mid-frame.
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    rst = 1'b1; tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_rx_enable", 32'(rx_enable), 32'd0);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_cmd", 32'(frame_cmd), 32'd0);
    chk("rst_len", 32'(frame_len), 32'd0);
    rd_addr = 4'd0; #1;
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0; tick();
    chk("rst_release_rx_enable", 32'(rx_enable), 32'd1);

    repeat (2) tick();
    chk("pulse_width", 32'(c_long), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
